se_sram_mrw_2_be_init: RTL
==========================

Name: se_sram_mrw_2_be_init

Overview:
Parametrised dual-port synchronous SRAM on one clock. It succeeds the fixed-size se_sram_mrw_2_* wrappers and adds the following:
- per-byte write enables
- deterministic same-address collision resolution with write-through bypass
- a registered collision flag
- a self-clearing initialisation sequencer run after reset

It sits under the frame-buffer and packet-store blocks that currently rely on initfile contents and undefined collision behaviour.

Parameters:
address_width, 11, address bits per port; depth = 2**address_width
data_width, 32, word width in bits
byte_width, 8, bits per byte-enable lane; data_width must be an exact multiple
init_value, 0, value (data_width bits) written to every location after reset

Ports:
sram_clock  input  1  single clock for both ports
reset_n  input  1  synchronous reset, active low
sram_clock__enable  input  1  clock qualifier; when low, no state changes anywhere
select_0  input  1  port 0 access request
read_not_write_0  input  1  port 0: 1 = read, 0 = write
address_0  input  address_width  port 0 address
write_data_0  input  data_width  port 0 write data
byte_enable_0  input  data_width/byte_width  port 0 write lane enables
data_out_0  output  data_width  port 0 registered read data
select_1, read_not_write_1, address_1, write_data_1, byte_enable_1, data_out_1: as port 0, for port 1
init_busy  output  1  high while the initialisation sequencer owns the array
collision  output  1  one-cycle pulse on a same-address access conflict

Behaviour:
- Clock and reset:
  - Only one clock exists; reset is synchronous and active-low.
  - Reset is sampled on the rising sram_clock edge regardless of sram_clock__enable.
- Reset values: data_out_0 = 0, data_out_1 = 0, init_busy = 1, collision = 0, internal init_addr = 0, state = INIT.
- Gating: every non-reset update is gated by sram_clock__enable. With enable low, the array, data_out, flags and init_addr all hold.
- State INIT:
  - Each enabled cycle writes init_value to mem[init_addr], then init_addr increments.
  - Port selects are ignored, data_out_* hold 0 and collision stays 0.
  - After the write to address 2**address_width-1, state becomes RUN and init_busy is 0 from that edge.
  - INIT lasts exactly 2**address_width enabled cycles.
  - Reset asserted mid-INIT restarts at init_addr = 0.
- State RUN, read:
  - select_n=1 and read_not_write_n=1 load data_out_n with mem[address_n] on the edge. Latency is 1 enabled cycle.
  - data_out_n holds its value on any cycle without a read on that port.
- State RUN, write:
  - select_n=1 and read_not_write_n=0 write only the lanes with byte_enable_n[i]=1, i.e. bits [i*byte_width +: byte_width]. Other lanes keep their old contents.
  - data_out_n is unchanged by a write.
- Same address, both writing:
  - The stored word is merged per lane.
  - A lane with be_0 set takes port 0 data.
  - Otherwise, a lane with be_1 set takes port 1 data.
  - Otherwise, the lane keeps its old value.
  - collision = 1 for one cycle.
- Same address, one reading and one writing:
  - The reader gets the post-write (merged) word: write-through bypass.
  - collision = 1 for one cycle.
- Same address, both reading: normal reads, collision = 0.
- Different addresses: ports are fully independent, collision = 0.
- collision is registered and is cleared on any enabled cycle without a conflict.
- Reset in RUN: returns to INIT and the whole array is re-cleared; prior contents are not retained.
- Address wrap: init_addr does not wrap. The transition to RUN occurs at the terminal address.

Test Plan:
- address_width=4, init_value=32'hA5A5A5A5, release reset -> init_busy high for exactly 16 enabled cycles, then low; reads of addr 0 and addr 15 return 32'hA5A5A5A5 one cycle later.
- RUN: port 0 writes 32'h11223344 to addr 3 with be=4'b1111, then writes 32'hFFFFFFFF with be=4'b0101 -> port 1 read of addr 3 returns 32'h11FF33FF after 1 cycle.
- Both ports write addr 7 in the same cycle, be_0=4'b0011 with data 32'hAAAAAAAA, be_1=4'b1110 with data 32'hBBBBBBBB, over prior content 0 -> collision pulses 1 cycle; addr 7 reads 32'hBBBBAAAA.
- Port 0 writes 32'hDEADBEEF (be all 1) to addr 9 while port 1 reads addr 9 -> data_out_1 = 32'hDEADBEEF next cycle; collision = 1 for one cycle, then 0.
- sram_clock__enable held low 5 cycles during INIT and during a RUN read -> init_busy duration extends by 5 cycles; data_out, collision and array are unchanged while enable is low.
- Assert reset_n=0 for one cycle at init_addr=8 after writing 32'h12345678 in a prior RUN -> INIT restarts from 0, lasts 16 enabled cycles, and the old location reads init_value.

Source files
------------

// File: rtl/se_sram_mrw_2_be_init.sv
// -----------------------------------------------------------------------------
// se_sram_mrw_2_be_init
//
// Dual-port synchronous SRAM on a single clock. It has per-byte write enables,
// deterministic same-address collision handling with write-through bypass, a
// registered collision flag, and an initialisation sequencer. After every reset
// the sequencer fills the whole array with init_value.
//
// Ports
//   sram_clock          : single clock for both ports
//   reset_n             : synchronous reset, active low (ignores the enable)
//   sram_clock__enable  : clock qualifier; low freezes every piece of state
//   select_n            : port n access request
//   read_not_write_n    : port n direction, 1 = read, 0 = write
//   address_n           : port n word address
//   write_data_n        : port n write data
//   byte_enable_n       : port n write lane enables (one bit per byte_width lane)
//   data_out_n          : port n registered read data (1 enabled cycle latency)
//   init_busy           : high while the init sequencer owns the array
//   collision           : one-cycle pulse after a same-address conflict
// -----------------------------------------------------------------------------
module se_sram_mrw_2_be_init #(
  parameter int unsigned address_width = 11,
  parameter int unsigned data_width    = 32,
  parameter int unsigned byte_width    = 8,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                             sram_clock,
  input  logic                             reset_n,
  input  logic                             sram_clock__enable,
  input  logic                             select_0,
  input  logic                             read_not_write_0,
  input  logic [address_width-1:0]         address_0,
  input  logic [data_width-1:0]            write_data_0,
  input  logic [data_width/byte_width-1:0] byte_enable_0,
  output logic [data_width-1:0]            data_out_0,
  input  logic                             select_1,
  input  logic                             read_not_write_1,
  input  logic [address_width-1:0]         address_1,
  input  logic [data_width-1:0]            write_data_1,
  input  logic [data_width/byte_width-1:0] byte_enable_1,
  output logic [data_width-1:0]            data_out_1,
  output logic                             init_busy,
  output logic                             collision
);

  localparam int unsigned depth = 2 ** address_width;
  localparam int unsigned lanes = data_width / byte_width;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] init_addr_q, init_addr_d;
  logic                     collision_q, collision_d;
  logic [data_width-1:0]    data_out_0_q, data_out_0_d;
  logic [data_width-1:0]    data_out_1_q, data_out_1_d;

  logic [data_width-1:0]    mem_q [depth];

  logic                     rd_0, wr_0, rd_1, wr_1;
  logic                     same_addr;
  logic [data_width-1:0]    res_0, res_1;

  // Replace the lanes of old_w whose enable bit is set with the lanes of new_w.
  function automatic logic [data_width-1:0] lane_merge(
    input logic [data_width-1:0] old_w,
    input logic [data_width-1:0] new_w,
    input logic [lanes-1:0]      be
  );
    logic [data_width-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(lanes); i++) begin
      if (be[i]) begin
        r[i*byte_width +: byte_width] = new_w[i*byte_width +: byte_width];
      end
    end
    return r;
  endfunction

  // Access decode. Port selects only count once the sequencer has released the array.
  always_comb begin
    rd_0      = (state_q == ST_RUN) && select_0 &&  read_not_write_0;
    wr_0      = (state_q == ST_RUN) && select_0 && !read_not_write_0;
    rd_1      = (state_q == ST_RUN) && select_1 &&  read_not_write_1;
    wr_1      = (state_q == ST_RUN) && select_1 && !read_not_write_1;
    same_addr = (address_0 == address_1);
  end

  // Post-write view of each port's addressed word. Port 1 lanes are applied
  // first so that port 0 wins any lane both ports enable. The same word is
  // what a writer stores and what a reader sees, which gives write-through
  // bypass on a read/write collision.
  always_comb begin
    res_0 = mem_q[address_0];
    if (wr_1 && same_addr) res_0 = lane_merge(res_0, write_data_1, byte_enable_1);
    if (wr_0)              res_0 = lane_merge(res_0, write_data_0, byte_enable_0);

    res_1 = mem_q[address_1];
    if (wr_1)              res_1 = lane_merge(res_1, write_data_1, byte_enable_1);
    if (wr_0 && same_addr) res_1 = lane_merge(res_1, write_data_0, byte_enable_0);
  end

  // Next-state logic: sequencer FSM, collision flag, read registers.
  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    collision_d  = 1'b0;
    data_out_0_d = data_out_0_q;
    data_out_1_d = data_out_1_q;

    unique case (state_q)
      ST_INIT: begin
        // The terminal address ends the sequence; the counter stops there and does not wrap.
        if (&init_addr_q) begin
          state_d = ST_RUN;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        collision_d = select_0 && select_1 && same_addr &&
                      !(read_not_write_0 && read_not_write_1);
        if (rd_0) data_out_0_d = res_0;
        if (rd_1) data_out_1_d = res_1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge sram_clock) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      collision_q  <= 1'b0;
      data_out_0_q <= '0;
      data_out_1_q <= '0;
    end else if (sram_clock__enable) begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      collision_q  <= collision_d;
      data_out_0_q <= data_out_0_d;
      data_out_1_q <= data_out_1_d;
    end
  end

  // Array: the sequencer fills it during INIT. In RUN, writers store their
  // resolved word. On a same-address double write both ports store the
  // identical merged word.
  always_ff @(posedge sram_clock) begin
    if (reset_n && sram_clock__enable) begin
      if (state_q == ST_INIT) begin
        mem_q[init_addr_q] <= init_value;
      end else begin
        if (wr_0) mem_q[address_0] <= res_0;
        if (wr_1) mem_q[address_1] <= res_1;
      end
    end
  end

  assign data_out_0 = data_out_0_q;
  assign data_out_1 = data_out_1_q;
  assign init_busy  = (state_q == ST_INIT);
  assign collision  = collision_q;

endmodule
